// File: rtl/d5m_axis_capture_if.sv
// -----------------------------------------------------------------------------
// d5m_axis_capture_if
//
// Purpose : AXI4-Stream video bundle carried out of the D5M capture block.
//
// Signals : tready - sink ready (driven by the slave)
//           tvalid - beat valid
//           tdata  - TDATA_WIDTH bits, pixel 0 in the LSBs
//           tuser  - start of frame, set on the first beat of a frame
//           tlast  - end of line, set on the last beat of a line
//
// Modports: master - the capture block (drives tvalid/tdata/tuser/tlast)
//           slave  - the downstream consumer (drives tready)
// -----------------------------------------------------------------------------
interface d5m_axis_capture_if #(
   parameter int unsigned TDATA_WIDTH = 12
) ();

   logic                   tready;
   logic                   tvalid;
   logic [TDATA_WIDTH-1:0] tdata;
   logic                   tuser;
   logic                   tlast;

   modport master (
      input  tready,
      output tvalid,
      output tdata,
      output tuser,
      output tlast
   );

   modport slave (
      output tready,
      input  tvalid,
      input  tdata,
      input  tuser,
      input  tlast
   );

endinterface

// File: rtl/d5m_axis_capture.sv
// -----------------------------------------------------------------------------
// d5m_axis_capture
//
// Purpose : Captures Bayer pixels from a Terasic D5M style parallel sensor port
//           (ifval / ilval / idata), packs PPC pixels per beat and emits them on
//           an AXI4-Stream master through a first-word-fall-through FIFO.
//           tuser marks the first beat of a frame, tlast the last beat of a line.
//
// Parameters:
//   DATA_WIDTH - bits per Bayer pixel
//   PPC        - pixels packed per output beat (1, 2 or 4)
//   FIFO_DEPTH - output buffer depth in beats (power of two, >= 4)
//
// Ports:
//   rgb_m_axis_aclk    - sole clock
//   rgb_m_axis_aresetn - synchronous active-low reset
//   ifval / ilval      - frame valid / line valid from the sensor
//   idata              - pixel, sampled while ifval & ilval
//   test_en            - (optional) replace idata by the in-line pixel index
//   ovf_clr            - clears the sticky overflow flag
//   overflow           - set when a beat was dropped on a full FIFO
//   frame_cnt          - number of completed frames (wraps)
//   line_pixels        - pixel count of the last completed line
//   rgb_m_axis         - AXI4-Stream master (tready/tvalid/tdata/tuser/tlast)
//
// Build option:
//   D5M_CAPTURE_TEST_PATTERN_EN - when defined adds the test_en input, which
//   substitutes idata with a per-line ramp (0 at the first pixel of each line).
// -----------------------------------------------------------------------------
module d5m_axis_capture #(
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned PPC        = 1,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                  rgb_m_axis_aclk,
   input  logic                  rgb_m_axis_aresetn,
   input  logic                  ifval,
   input  logic                  ilval,
   input  logic [DATA_WIDTH-1:0] idata,
`ifdef D5M_CAPTURE_TEST_PATTERN_EN
   input  logic                  test_en,
`endif
   input  logic                  ovf_clr,
   output logic                  overflow,
   output logic [15:0]           frame_cnt,
   output logic [15:0]           line_pixels,
   d5m_axis_capture_if.master    rgb_m_axis
);

   localparam int unsigned BeatW  = PPC * DATA_WIDTH;
   localparam int unsigned CntW   = $clog2(PPC + 1);
   localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
   localparam int unsigned EntryW = BeatW + 2;

   typedef enum logic [1:0] {
      StIdle,
      StWaitLine,
      StInLine,
      StFlush
   } state_e;

   state_e state_q, state_d;

   logic ifval_q;
   logic line_active;
   logic fval_rise;

   // FSM decoded controls
   logic frame_start;
   logic frame_end;
   logic line_start;
   logic pix_take;
   logic line_end;
   logic flush;

   // Pixel packing
   logic [DATA_WIDTH-1:0] pix;
   logic [BeatW-1:0]      pack_q, pack_d;
   logic [CntW-1:0]       pack_cnt_q, pack_cnt_d;
   logic [BeatW-1:0]      pend_q, pend_d;
   logic                  pend_vld_q, pend_vld_d;
   logic [15:0]           line_cnt_q, line_cnt_d;
   logic [15:0]           line_pixels_q, line_pixels_d;
   logic [15:0]           frame_cnt_q, frame_cnt_d;
   logic                  sof_q, sof_d;
   logic                  overflow_q, overflow_d;

   // FIFO
   logic              wr_en;
   logic              wr_last;
   logic [EntryW-1:0] wr_entry;
   logic [EntryW-1:0] mem_q [FIFO_DEPTH];
   logic [EntryW-1:0] rd_entry;
   logic [PtrW:0]     wr_ptr_q, wr_ptr_d;
   logic [PtrW:0]     rd_ptr_q, rd_ptr_d;
   logic              fifo_empty;
   logic              fifo_full;
   logic              rd_en;
   logic              wr_ok;
   logic              drop;

   assign line_active = ifval & ilval;
   // ifval_q resets high so a frame already running at reset exit never
   // looks like a rising edge.
   assign fval_rise   = ifval & ~ifval_q;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge rgb_m_axis_aclk) begin
      if (!rgb_m_axis_aresetn) begin
         state_q <= StIdle;
         ifval_q <= 1'b1;
      end else begin
         state_q <= state_d;
         ifval_q <= ifval;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (fval_rise) state_d = StWaitLine;
         end
         StWaitLine: begin
            if (!ifval)     state_d = StIdle;
            else if (ilval) state_d = StInLine;
         end
         StInLine: begin
            if (!line_active) state_d = StFlush;
         end
         StFlush: begin
            state_d = StWaitLine;
         end
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: decoded outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      frame_start = (state_q == StIdle) && fval_rise;
      frame_end   = (state_q == StWaitLine) && !ifval;
      line_start  = (state_q == StWaitLine) && line_active;
      pix_take    = line_start || ((state_q == StInLine) && line_active);
      line_end    = (state_q == StInLine) && !line_active;
      flush       = (state_q == StFlush);
   end

   // ---------------------------------------------------------------------------
   // Pixel source
   // ---------------------------------------------------------------------------
`ifdef D5M_CAPTURE_TEST_PATTERN_EN
   logic [15:0] line_idx;

   always_comb begin
      line_idx = line_start ? 16'd0 : line_cnt_q;
      pix      = test_en ? DATA_WIDTH'(line_idx) : idata;
   end
`else
   always_comb begin
      pix = idata;
   end
`endif

   // ---------------------------------------------------------------------------
   // Packing, pending beat and status next-state
   //
   // The pack register always keeps at least the latest pixel of a line; it only
   // moves to the pending register when the next pixel arrives or the line ends.
   // The pending beat therefore knows whether it is the last one of the line.
   // ---------------------------------------------------------------------------
   always_comb begin
      pack_d        = pack_q;
      pack_cnt_d    = pack_cnt_q;
      pend_d        = pend_q;
      pend_vld_d    = pend_vld_q;
      line_cnt_d    = line_cnt_q;
      line_pixels_d = line_pixels_q;
      frame_cnt_d   = frame_cnt_q;
      sof_d         = sof_q;
      wr_en         = 1'b0;
      wr_last       = 1'b0;

      if (frame_start) sof_d = 1'b1;

      if (pix_take) begin
         line_cnt_d = line_start ? 16'd1 : line_cnt_q + 16'd1;

         if (pack_cnt_q == CntW'(PPC)) begin
            pend_d     = pack_q;
            pend_vld_d = 1'b1;
            wr_en      = pend_vld_q;
         end

         if ((pack_cnt_q == CntW'(PPC)) || (pack_cnt_q == '0)) begin
            // Start a fresh pack; upper slots stay zero for padding.
            pack_d                   = '0;
            pack_d[DATA_WIDTH-1:0]   = pix;
            pack_cnt_d               = CntW'(1);
         end else begin
            for (int i = 1; i < int'(PPC); i++) begin
               if (pack_cnt_q == CntW'(i)) pack_d[i*DATA_WIDTH +: DATA_WIDTH] = pix;
            end
            pack_cnt_d = pack_cnt_q + CntW'(1);
         end
      end

      if (line_end) begin
         // Full or partial (already zero padded) pack becomes the tlast beat.
         pend_d     = pack_q;
         pend_vld_d = 1'b1;
         wr_en      = pend_vld_q;
         pack_d     = '0;
         pack_cnt_d = '0;
      end

      if (flush) begin
         wr_en         = pend_vld_q;
         wr_last       = 1'b1;
         pend_vld_d    = 1'b0;
         line_pixels_d = line_cnt_q;
      end

      if (frame_end) frame_cnt_d = frame_cnt_q + 16'd1;

      if (wr_en) sof_d = 1'b0;
   end

   always_ff @(posedge rgb_m_axis_aclk) begin
      if (!rgb_m_axis_aresetn) begin
         pack_q        <= '0;
         pack_cnt_q    <= '0;
         pend_q        <= '0;
         pend_vld_q    <= 1'b0;
         line_cnt_q    <= '0;
         line_pixels_q <= '0;
         frame_cnt_q   <= '0;
         sof_q         <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         pack_q        <= pack_d;
         pack_cnt_q    <= pack_cnt_d;
         pend_q        <= pend_d;
         pend_vld_q    <= pend_vld_d;
         line_cnt_q    <= line_cnt_d;
         line_pixels_q <= line_pixels_d;
         frame_cnt_q   <= frame_cnt_d;
         sof_q         <= sof_d;
         overflow_q    <= overflow_d;
      end
   end

   // ---------------------------------------------------------------------------
   // First-word-fall-through output FIFO
   // ---------------------------------------------------------------------------
   assign wr_entry   = {sof_q, wr_last, pend_q};
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                       (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
   assign rd_en      = !fifo_empty && rgb_m_axis.tready;
   // A read in the same cycle frees the slot, so a full FIFO still accepts.
   assign wr_ok      = wr_en && (!fifo_full || rd_en);
   assign drop       = wr_en && fifo_full && !rd_en;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + (PtrW+1)'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
      // Set wins over clear.
      if (drop)         overflow_d = 1'b1;
      else if (ovf_clr) overflow_d = 1'b0;
   end

   always_ff @(posedge rgb_m_axis_aclk) begin
      if (!rgb_m_axis_aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: nothing is visible while the FIFO is empty.
   always_ff @(posedge rgb_m_axis_aclk) begin
      if (wr_ok) mem_q[wr_ptr_q[PtrW-1:0]] <= wr_entry;
   end

   assign rd_entry = mem_q[rd_ptr_q[PtrW-1:0]];

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      rgb_m_axis.tvalid = !fifo_empty;
      rgb_m_axis.tdata  = fifo_empty ? '0 : rd_entry[BeatW-1:0];
      rgb_m_axis.tlast  = !fifo_empty && rd_entry[BeatW];
      rgb_m_axis.tuser  = !fifo_empty && rd_entry[BeatW+1];
      overflow          = overflow_q;
      frame_cnt         = frame_cnt_q;
      line_pixels       = line_pixels_q;
   end

endmodule

// File: tb/tb_d5m_axis_capture.sv
// Self-checking bench for d5m_axis_capture (PPC=4, FIFO_DEPTH=4).
// Stimulus pushes expected beats into a queue; a negedge monitor pops and
// compares on every handshake and checks that stalled beats stay stable.
module tb_d5m_axis_capture;

   localparam int unsigned DW    = 12;
   localparam int unsigned PPC   = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned TW    = DW * PPC;

   typedef struct packed {
      logic [TW-1:0] data;
      logic          user;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ifval;
   logic          ilval;
   logic [DW-1:0] idata;
   logic          ovf_clr;
   logic          overflow;
   logic [15:0]   frame_cnt;
   logic [15:0]   line_pixels;

   int    checks = 0;
   int    errors = 0;
   beat_t exp_q[$];
   int    tready_mode = 1;  // 0: hold low, 1: hold high, 2: random
   int    model_frames = 0;
   int    model_last_len = 0;
   bit    model_sof = 1'b0;
   bit    stall_seen = 1'b0;
   beat_t stall_beat;

   always #5 clk = ~clk;

   d5m_axis_capture_if #(.TDATA_WIDTH(TW)) axis_if ();

   d5m_axis_capture #(
      .DATA_WIDTH (DW),
      .PPC        (PPC),
      .FIFO_DEPTH (DEPTH)
   ) u_dut (
      .rgb_m_axis_aclk    (clk),
      .rgb_m_axis_aresetn (rst_n),
      .ifval              (ifval),
      .ilval              (ilval),
      .idata              (idata),
`ifdef D5M_CAPTURE_TEST_PATTERN_EN
      .test_en            (1'b0),
`endif
      .ovf_clr            (ovf_clr),
      .overflow           (overflow),
      .frame_cnt          (frame_cnt),
      .line_pixels        (line_pixels),
      .rgb_m_axis         (axis_if)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model of one line: PPC pixels per beat, zero padded, tlast on
   // the final beat, tuser on the first beat of the frame. Only the first
   // 'keep' beats survive (FIFO capacity when the sink never reads).
   task automatic model_line(input logic [DW-1:0] px[$], input int keep);
      int nb;
      nb = (px.size() + PPC - 1) / PPC;
      for (int b = 0; b < nb; b++) begin
         beat_t e;
         e.data = '0;
         for (int s = 0; s < PPC; s++) begin
            if (b * PPC + s < px.size()) e.data[s*DW +: DW] = px[b*PPC+s];
         end
         e.last    = (b == nb - 1);
         e.user    = model_sof;
         model_sof = 1'b0;
         if (b < keep) exp_q.push_back(e);
      end
      model_last_len = px.size();
   endtask

   task automatic drive_px(input logic [DW-1:0] px[$], input bit drop_fval, input int keep);
      model_line(px, keep);
      for (int i = 0; i < px.size(); i++) begin
         ilval = 1'b1;
         idata = px[i];
         tick();
      end
      ilval = 1'b0;
      idata = DW'($urandom);
      if (drop_fval) ifval = 1'b0;
      tick();
   endtask

   task automatic drive_rand(input int len, input bit drop_fval, input int keep);
      logic [DW-1:0] px[$];
      for (int i = 0; i < len; i++) px.push_back(DW'($urandom));
      drive_px(px, drop_fval, keep);
   endtask

   task automatic start_frame();
      ifval     = 1'b1;
      model_sof = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
   endtask

   task automatic end_frame();
      ifval = 1'b0;
      model_frames++;
      repeat (4) tick();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d beats outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(model_frames));
      chk({tag, "_line_pixels"}, 64'(line_pixels), 64'(model_last_len));
   endtask

   // tready driver
   initial begin
      axis_if.tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tready_mode == 2) axis_if.tready = 1'($urandom_range(0, 1));
         else                  axis_if.tready = (tready_mode == 1);
      end
   end

   // Monitor / scoreboard
   initial begin
      beat_t cur;
      beat_t e;
      forever begin
         @(negedge clk);
         cur = {axis_if.tdata, axis_if.tuser, axis_if.tlast};
         if (rst_n === 1'b1) begin
            if (stall_seen && axis_if.tvalid) chk("stall_hold", 64'(cur), 64'(stall_beat));
            if (axis_if.tvalid && axis_if.tready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got tdata 0x%0h, required no beat",
                           axis_if.tdata);
               end else begin
                  e = exp_q.pop_front();
                  chk("tdata", 64'(axis_if.tdata), 64'(e.data));
                  chk("tuser", 64'(axis_if.tuser), 64'(e.user));
                  chk("tlast", 64'(axis_if.tlast), 64'(e.last));
               end
            end
            stall_seen = axis_if.tvalid && !axis_if.tready;
            stall_beat = cur;
         end else begin
            stall_seen = 1'b0;
         end
      end
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] dpx[$];
      int            nl;

      rst_n   = 1'b0;
      ifval   = 1'b0;
      ilval   = 1'b0;
      idata   = '0;
      ovf_clr = 1'b0;
      repeat (3) tick();

      // Reset state
      chk("rst_tvalid", 64'(axis_if.tvalid), 64'd0);
      chk("rst_tdata", 64'(axis_if.tdata), 64'd0);
      chk("rst_tuser", 64'(axis_if.tuser), 64'd0);
      chk("rst_tlast", 64'(axis_if.tlast), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("rst_line_pixels", 64'(line_pixels), 64'd0);
      rst_n = 1'b1;
      tick();

      // Directed frame: line of 6 pixels 0x101..0x106 gives a padded tlast beat
      tready_mode = 1;
      start_frame();
      dpx = '{12'h101, 12'h102, 12'h103, 12'h104, 12'h105, 12'h106};
      drive_px(dpx, 1'b0, 1000);
      tick();
      drain();
      end_frame();
      check_status("directed");

      // Randomised frames with random backpressure
      tready_mode = 2;
      for (int f = 0; f < 6; f++) begin
         start_frame();
         nl = $urandom_range(1, 3);
         for (int l = 0; l < nl; l++) begin
            // Odd frames drop ifval together with ilval on their final line.
            drive_rand($urandom_range(1, 12), (l == nl - 1) && (f % 2 == 1), 1000);
            repeat ($urandom_range(1, 4)) tick();
            drain();
         end
         end_frame();
         check_status("random");
      end

      // Overflow: sink stalled, 24 pixels -> 6 beats into a 4-deep FIFO
      tready_mode = 0;
      repeat (2) tick();
      start_frame();
      drive_rand(24, 1'b0, DEPTH);
      repeat (2) tick();
      chk("ovf_set", 64'(overflow), 64'd1);
      chk("ovf_tvalid_held", 64'(axis_if.tvalid), 64'd1);
      tready_mode = 1;
      drain();
      chk("ovf_sticky", 64'(overflow), 64'd1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("ovf_cleared", 64'(overflow), 64'd0);
      end_frame();
      check_status("overflow");

      // Reset mid-line with buffered beats, then a frame in progress at reset exit
      tready_mode = 0;
      repeat (2) tick();
      ifval     = 1'b1;
      model_sof = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         ilval = 1'b1;
         idata = DW'($urandom);
         tick();
      end
      chk("pre_rst_tvalid", 64'(axis_if.tvalid), 64'd1);
      rst_n = 1'b0;
      tick();
      exp_q.delete();
      model_frames   = 0;
      model_last_len = 0;
      chk("midrst_tvalid", 64'(axis_if.tvalid), 64'd0);
      chk("midrst_tlast", 64'(axis_if.tlast), 64'd0);
      rst_n       = 1'b1;
      tready_mode = 1;
      // Lines of the frame running across reset exit must produce nothing.
      for (int l = 0; l < 2; l++) begin
         repeat (4) begin
            ilval = 1'b1;
            idata = DW'($urandom);
            tick();
         end
         ilval = 1'b0;
         repeat (3) tick();
      end
      ifval = 1'b0;
      repeat (4) tick();
      chk("ignored_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("ignored_tvalid", 64'(axis_if.tvalid), 64'd0);

      start_frame();
      drive_rand(4, 1'b0, 1000);
      tick();
      drive_rand(7, 1'b0, 1000);
      tick();
      drain();
      end_frame();
      check_status("recover");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
